// File: rtl/debounce_fsm.sv
// -----------------------------------------------------------------------------
// debounce_fsm
//   Conditions one raw, bouncing, active-low pushbutton: a two-flop
//   synchronizer, a four-state debounce machine with a saturating stability
//   counter, and a rising-edge detector on the debounced level.
//
// Handshake: none. This is a free-running level/pulse stage; oPressed is a
// level and oPress_pulse is a single-cycle strobe, both valid every cycle.
//
// Ports
//   iClk          in   system clock, rising edge
//   inReset       in   asynchronous reset, active low
//   inBtn         in   raw button, 0 = pressed, asynchronous to iClk
//   oPressed      out  debounced level, 1 while the press is accepted
//   oPress_pulse  out  one-cycle pulse on the cycle oPressed first rises
// -----------------------------------------------------------------------------
module debounce_fsm #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic iClk,
    input  logic inReset,
    input  logic inBtn,
    output logic oPressed,
    output logic oPress_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic          s;
    logic          db;

    // The raw input is inverted on entry so the synchronized sample is 1
    // while the button is held down.
    assign sync1_d = ~inBtn;
    assign sync2_d = sync1_q;
    assign s       = sync2_q;

    // State register, synchronizer and edge-detect history.
    always_ff @(posedge iClk or negedge inReset) begin
        if (!inReset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
        end
    end

    // Next-state logic. In the two WAIT states the counter counts consecutive
    // samples that agree with the pending transition; it stops at CNT_LAST
    // because that is exactly where the state moves on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the registered state only, so they never glitch.
    always_comb begin
        db           = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
        db_d         = db;
        oPressed     = db;
        oPress_pulse = db & ~db_q;
    end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Front end for the board's 4-bit up/down counter. Three raw active-low
//   buttons are debounced; run and direction become press-toggled levels,
//   load becomes a level stretched to at least LOAD_MIN cycles so the
//   counter's slow divided clock is guaranteed to see it.
//
// Handshake: none. All outputs are registered levels, valid every cycle.
//
// Ports
//   iClk        in   system clock, rising edge
//   inReset     in   asynchronous reset, active low
//   inBtn_run   in   raw run/pause button, 0 = pressed
//   inBtn_dir   in   raw direction button, 0 = pressed
//   inBtn_load  in   raw load button, 0 = pressed
//   oCount_en   out  count enable, toggles once per run press (reset 1)
//   oUp         out  direction, toggles once per dir press, 1 = up (reset 1)
//   oLoad       out  stretched load request (reset 0)
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEB_CYCLES = 500000,
    parameter int LOAD_MIN   = 10000000
) (
    input  logic iClk,
    input  logic inReset,
    input  logic inBtn_run,
    input  logic inBtn_dir,
    input  logic inBtn_load,
    output logic oCount_en,
    output logic oUp,
    output logic oLoad
);

    localparam int SW = $clog2(LOAD_MIN);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(LOAD_MIN - 1);

    logic run_pulse, dir_pulse, load_pulse, load_db;
    // Run and direction only act on the press edge; their held levels are
    // left unused.
    logic run_held_unused, dir_held_unused;

    logic          count_en_q, count_en_d;
    logic          up_q, up_d;
    logic          load_q, load_d;
    logic [SW-1:0] stretch_q, stretch_d;

    debounce_fsm #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .iClk         (iClk),
        .inReset      (inReset),
        .inBtn        (inBtn_run),
        .oPressed     (run_held_unused),
        .oPress_pulse (run_pulse)
    );

    debounce_fsm #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .iClk         (iClk),
        .inReset      (inReset),
        .inBtn        (inBtn_dir),
        .oPressed     (dir_held_unused),
        .oPress_pulse (dir_pulse)
    );

    debounce_fsm #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .iClk         (iClk),
        .inReset      (inReset),
        .inBtn        (inBtn_load),
        .oPressed     (load_db),
        .oPress_pulse (load_pulse)
    );

    always_ff @(posedge iClk or negedge inReset) begin
        if (!inReset) begin
            count_en_q <= 1'b1;
            up_q       <= 1'b1;
            load_q     <= 1'b0;
            stretch_q  <= '0;
        end else begin
            count_en_q <= count_en_d;
            up_q       <= up_d;
            load_q     <= load_d;
            stretch_q  <= stretch_d;
        end
    end

    always_comb begin
        count_en_d = count_en_q ^ run_pulse;
        up_d       = up_q ^ dir_pulse;
        load_d     = load_q;
        stretch_d  = stretch_q;
        if (!load_q) begin
            // oLoad can only fall once the debounced level is low, so every
            // start of a stretch coincides with a fresh press pulse.
            if (load_pulse) begin
                load_d    = 1'b1;
                stretch_d = '0;
            end
        end else if (load_db || (stretch_q < STRETCH_LAST)) begin
            // A repeat press while high only extends through load_db; the
            // stretch counter keeps running and parks at its last value.
            if (stretch_q < STRETCH_LAST) begin
                stretch_d = stretch_q + 1'b1;
            end
        end else begin
            load_d = 1'b0;
        end
    end

    assign oCount_en = count_en_q;
    assign oUp       = up_q;
    assign oLoad     = load_q;

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/100ps
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int LMIN = 10;

    // Clock / reset
    logic iClk       = 1'b0;
    logic inReset    = 1'b0;
    logic inBtn_run  = 1'b1;
    logic inBtn_dir  = 1'b1;
    logic inBtn_load = 1'b1;
    logic oCount_en, oUp, oLoad;

    always #2.5 iClk = ~iClk;

    button_conditioner #(.DEB_CYCLES(DEB), .LOAD_MIN(LMIN)) dut (
        .iClk       (iClk),
        .inReset    (inReset),
        .inBtn_run  (inBtn_run),
        .inBtn_dir  (inBtn_dir),
        .inBtn_load (inBtn_load),
        .oCount_en  (oCount_en),
        .oUp        (oUp),
        .oLoad      (oLoad)
    );

    // Scoreboard: expected {oCount_en, oUp, oLoad}
    logic [2:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       run;
        logic       dir;
        logic       load;
        int         cycles;
        logic [2:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got en/up/load=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: inputs change on the falling edge, away from sampling.
    task automatic drive(input logic r, input logic d, input logic l);
        @(negedge iClk);
        inBtn_run  = r;
        inBtn_dir  = d;
        inBtn_load = l;
    endtask

    task automatic step(input logic r, input logic d, input logic l);
        drive(r, d, l);
        @(posedge iClk);
        #1;
    endtask

    // One cycle with a per-cycle scoreboard check after the edge.
    task automatic cyc(input logic r, input logic d, input logic l,
                       input logic [2:0] exp, input string name);
        drive(r, d, l);
        exp_q.push_back(exp);
        @(posedge iClk);
        #1;
        check(name, {oCount_en, oUp, oLoad}, exp_q.pop_front());
    endtask

    task automatic apply_reset();
        @(negedge iClk);
        inReset    = 1'b0;
        inBtn_run  = 1'b1;
        inBtn_dir  = 1'b1;
        inBtn_load = 1'b1;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        inReset = 1'b1;
        @(posedge iClk);
        #1;
        exp_q.push_back(3'b110);
        check("reset_values", {oCount_en, oUp, oLoad}, exp_q.pop_front());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] e;
        logic       b;

        vecs[0]  = '{1'b1, 1'b1, 1'b1,  5, 3'b110, "tbl_idle"};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 20, 3'b010, "tbl_run_press"};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 12, 3'b010, "tbl_run_release"};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 20, 3'b000, "tbl_dir_press"};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 12, 3'b000, "tbl_dir_release"};
        vecs[5]  = '{1'b1, 1'b1, 1'b0,  3, 3'b000, "tbl_load_glitch"};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 15, 3'b000, "tbl_after_glitch"};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 20, 3'b110, "tbl_both_press"};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 12, 3'b110, "tbl_both_release"};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 20, 3'b111, "tbl_load_held"};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 20, 3'b110, "tbl_load_release"};

        // Power-on reset
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        inReset = 1'b1;
        @(posedge iClk);
        #1;
        exp_q.push_back(3'b110);
        check("por_values", {oCount_en, oUp, oLoad}, exp_q.pop_front());

        // Table-driven segments, checked at the end of each segment
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(vecs[i].exp);
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step(vecs[i].run, vecs[i].dir, vecs[i].load);
            end
            check(vecs[i].name, {oCount_en, oUp, oLoad}, exp_q.pop_front());
        end

        // Run press timing: toggle lands 7 edges after the first sampling edge
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            e = (k >= 8) ? 3'b010 : 3'b110;
            cyc(1'b0, 1'b1, 1'b1, e, "run_press1");
        end
        for (int k = 1; k <= 12; k++) cyc(1'b1, 1'b1, 1'b1, 3'b010, "run_release1");
        for (int k = 1; k <= 20; k++) begin
            e = (k >= 8) ? 3'b110 : 3'b010;
            cyc(1'b0, 1'b1, 1'b1, e, "run_press2");
        end
        for (int k = 1; k <= 12; k++) cyc(1'b1, 1'b1, 1'b1, 3'b110, "run_release2");

        // Bounce on dir: no toggle, then bounce followed by a hold: one toggle
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            b = (((k - 1) / 2) % 2 == 0) ? 1'b0 : 1'b1;
            cyc(1'b1, b, 1'b1, 3'b110, "dir_bounce");
        end
        for (int k = 1; k <= 10; k++) cyc(1'b1, 1'b1, 1'b1, 3'b110, "dir_bounce_idle");
        for (int k = 1; k <= 16; k++) begin
            b = (((k - 1) / 2) % 2 == 0) ? 1'b0 : 1'b1;
            cyc(1'b1, b, 1'b1, 3'b110, "dir_bounce2");
        end
        for (int h = 1; h <= 20; h++) begin
            e = (h >= 8) ? 3'b100 : 3'b110;
            cyc(1'b1, 1'b0, 1'b1, e, "dir_bounce_hold");
        end
        for (int k = 1; k <= 12; k++) cyc(1'b1, 1'b1, 1'b1, 3'b100, "dir_hold_release");

        // Short load: 6-cycle press, oLoad high exactly LMIN cycles
        apply_reset();
        for (int k = 1; k <= 25; k++) begin
            b = (k <= 6) ? 1'b0 : 1'b1;
            e = {2'b11, (k >= 8 && k <= 7 + LMIN)};
            cyc(1'b1, 1'b1, b, e, "load_short");
        end

        // Long load: 30-cycle press, oLoad follows the debounced release
        apply_reset();
        for (int k = 1; k <= 45; k++) begin
            b = (k <= 30) ? 1'b0 : 1'b1;
            e = {2'b11, (k >= 8 && k <= 37)};
            cyc(1'b1, 1'b1, b, e, "load_long");
        end

        // Simultaneous run and dir: both toggle on the same edge
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            e = (k >= 8) ? 3'b000 : 3'b110;
            cyc(1'b0, 1'b0, 1'b1, e, "both_press");
        end
        for (int k = 1; k <= 12; k++) cyc(1'b1, 1'b1, 1'b1, 3'b000, "both_release");

        // Reset asserted mid-cycle while run is in PRESS_WAIT
        for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b1, 1'b1, 3'b000, "pw_press");
        inReset = 1'b0;
        #0.5;
        exp_q.push_back(3'b110);
        check("async_reset", {oCount_en, oUp, oLoad}, exp_q.pop_front());
        inBtn_run = 1'b1;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        inReset = 1'b1;
        for (int k = 1; k <= 20; k++) cyc(1'b1, 1'b1, 1'b1, 3'b110, "after_pw_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage that sits directly upstream of the 4-bit up/down counter on the FPGA board.
- Takes three raw, bouncing, active-low pushbuttons: run, direction and load.
- Produces clean control levels for the counter's count-enable, up/down and load inputs.
- Each button has its own synchronizer and debounce FSM. Run and direction are press-toggled levels. Load is a stretched level, so the counter's slow divided clock always samples it.

Parameters:
- DEB_CYCLES, 500000: consecutive stable synchronized samples needed to accept a press or a release (10 ms at 50 MHz).
- LOAD_MIN, 10000000: minimum number of iClk cycles oLoad stays high once asserted. Set it to at least one divided-clock period of the counter.

Ports:
- iClk  input  1  system clock; all state changes on its rising edge.
- inReset  input  1  asynchronous, active-low reset.
- inBtn_run  input  1  raw run/pause button; 0 = pressed; asynchronous to iClk.
- inBtn_dir  input  1  raw direction button; 0 = pressed; asynchronous.
- inBtn_load  input  1  raw load button; 0 = pressed; asynchronous.
- oCount_en  output  1  count enable, registered; connects to the counter's iCount_en.
- oUp  output  1  direction, registered; 1 = up; connects to the counter's iUp.
- oLoad  output  1  load request, registered; connects to the counter's iLoad.

Behaviour:
- Reset:
  - Asynchronous reset while inReset = 0; all outputs and state are registered.
  - Reset values: oCount_en = 1, oUp = 1, oLoad = 0, every FSM in RELEASED, all counters 0, synchronizer flops hold the "not pressed" value.
  - Reset asserted mid-debounce or mid-stretch aborts that activity immediately. No toggle or load pulse results from it.
- Synchronizer: two-flop synchronizer per button. The inverted raw input gives s = 1 when pressed. s is valid 2 edges after the raw change.
- Debounce FSM, one per button, with a counter of width $clog2(DEB_CYCLES):
  - RELEASED: s = 1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: s = 0 -> RELEASED. Otherwise the counter increments; at count DEB_CYCLES-1 with s = 1 -> PRESSED.
  - PRESSED: s = 0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: s = 1 -> PRESSED. Otherwise the counter increments; at count DEB_CYCLES-1 with s = 0 -> RELEASED.
  - Debounced output db = 1 in PRESSED and RELEASE_WAIT.
  - Any glitch shorter than DEB_CYCLES samples never changes db.
- Latency: a clean press held steady gives db = 1 exactly 2 + DEB_CYCLES edges after the first sampling edge.
- Toggles:
  - press_pulse = db & ~db_q, a one-cycle pulse.
  - oCount_en inverts on the edge after the run button's pulse; oUp inverts on the edge after the direction button's pulse.
  - Total latency from a press to the toggle is 3 + DEB_CYCLES edges.
  - Holding a button produces exactly one toggle; a release produces none.
  - Run and direction pressed simultaneously: both toggle on the same edge; they are independent.
- Load stretch:
  - oLoad goes to 1 on the edge after load db rises, and a stretch counter starts at 0.
  - oLoad stays 1 while db = 1 OR the stretch counter < LOAD_MIN-1.
  - oLoad drops to 0 on the first edge where both conditions are false.
  - Minimum high time is LOAD_MIN cycles; otherwise it follows the debounced button.
  - A new press while oLoad is still high does not restart the stretch counter; it only extends oLoad through db.
- Width rules: counters saturate, never wrap. The stretch counter holds at LOAD_MIN-1.
- DEB_CYCLES and LOAD_MIN must be >= 2; values below that are unsupported.

Decomposition:
- No shared package is needed. The debounce state encoding (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT) is localparams inside the sub-module.
- Sub-module debounce_fsm (parameter DEB_CYCLES) contains:
  - ports iClk, inReset, inBtn, oPressed, oPress_pulse;
  - the synchronizer, the FSM and the edge detect.
- The top level instantiates debounce_fsm three times and adds the two toggle flops and the load stretcher.

Test Plan (DEB_CYCLES = 4, LOAD_MIN = 10, 5 ns clock):
- Reset: hold inReset = 0 with all buttons = 1, then release it. Required: oCount_en = 1, oUp = 1, oLoad = 0. Asserting inReset = 0 mid-cycle forces the same values immediately, without waiting for a clock edge.
- Run press: drop inBtn_run to 0 and hold it 20 cycles. Required: oCount_en goes to 0 exactly 7 edges after the first sampling edge, then stays 0. A second identical press returns it to 1.
- Bounce: toggle inBtn_dir 0/1 every 2 cycles for 16 cycles, then leave it at 1. Required: oUp stays 1 throughout. Toggling it every 2 cycles then holding 0 gives exactly one toggle, oUp = 0.
- Short load: a clean inBtn_load press held 6 cycles. Required: oLoad high for exactly 10 cycles, then 0.
- Long load: inBtn_load held 30 cycles. Required: oLoad stays 1 until the release debounces (DEB_CYCLES + 2 edges after release), then falls on the next edge.
- Simultaneous events: run and dir pressed on the same edge. Required: oCount_en and oUp toggle on the same edge. A press with reset asserted during PRESS_WAIT produces no toggle.
